// File: rtl/frv_pipeline_fetch_pq.sv
// frv_pipeline_fetch_pq: prefetching fetch stage with a halfword-granular instruction queue.
// Word reads are issued ahead of decode only while queue space is reserved for every in-flight response.
module frv_pipeline_fetch_pq #(
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] PC_RESET      = 32'h8000_0000,
    parameter int              PREFETCH_REQS = 4,
    parameter int              BUF_HW        = 8
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            i_cf_req,
    input  logic [XLEN-1:0] i_cf_target,
    output logic            o_cf_ack,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_recv,
    output logic            o_imem_ack,
    input  logic            i_imem_error,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic            o_s1_valid,
    input  logic            i_s1_busy,
    output logic [31:0]     o_s1_data,
    output logic            o_s1_size,
    output logic [XLEN-1:0] o_s1_pc,
    output logic            o_s1_error
);

    localparam int CW  = $clog2(PREFETCH_REQS + 1);
    localparam int OW  = $clog2(BUF_HW + 1);
    localparam int WW  = OW + 1;
    localparam int PW  = $clog2(BUF_HW);
    localparam int PW1 = PW + 1;

    localparam logic [CW-1:0]  MAX_OUT = CW'(PREFETCH_REQS);
    localparam logic [OW-1:0]  DEPTH   = OW'(BUF_HW);
    localparam logic [PW1-1:0] DEPTH_P = PW1'(BUF_HW);

    logic [15:0]     r_qData [BUF_HW];
    logic            r_qErr  [BUF_HW];
    logic [PW-1:0]   r_rdPtr;
    logic [PW-1:0]   r_wrPtr;
    logic [OW-1:0]   r_occ;
    logic [CW-1:0]   r_outCnt;
    logic [CW-1:0]   r_ignCnt;
    logic            r_misaligned;
    logic            r_imemReq;
    logic [XLEN-1:0] r_imemAddr;
    logic [XLEN-1:0] r_s1Pc;

    logic [PW-1:0]   w_rdPtr1;
    logic [PW-1:0]   w_wrPtr1;
    logic [15:0]     w_head0;
    logic [15:0]     w_head1;
    logic            w_headErr0;
    logic            w_headErr1;
    logic            w_is32;
    logic            w_s1Valid;
    logic            w_pop;
    logic [1:0]      w_popCnt;
    logic [OW-1:0]   w_freeHw;
    logic            w_ack;
    logic            w_rsp;
    logic            w_grant;
    logic            w_push;
    logic [1:0]      w_pushCnt;
    logic [CW-1:0]   w_outNext;
    logic [OW-1:0]   w_occNext;
    logic [WW-1:0]   w_freeNext;
    logic [WW-1:0]   w_needHw;
    logic            w_reqNext;

    // Queue pointers wrap at BUF_HW, which need not be a power of two.
    function automatic logic [PW-1:0] ptrAdd(input logic [PW-1:0] p, input logic [1:0] n);
        logic [PW1-1:0] s;
        s = PW1'(p) + PW1'(n);
        if (s >= DEPTH_P) begin
            s = s - DEPTH_P;
        end
        return s[PW-1:0];
    endfunction

    always_comb begin
        w_rdPtr1   = ptrAdd(r_rdPtr, 2'd1);
        w_wrPtr1   = ptrAdd(r_wrPtr, 2'd1);
        w_head0    = r_qData[r_rdPtr];
        w_head1    = r_qData[w_rdPtr1];
        w_headErr0 = r_qErr[r_rdPtr];
        w_headErr1 = r_qErr[w_rdPtr1];
        w_is32     = (w_head0[1:0] == 2'b11);
        w_s1Valid  = (r_occ != '0) && (!w_is32 || (r_occ >= OW'(2)));
        w_pop      = w_s1Valid & ~i_s1_busy & ~i_cf_req;
        w_popCnt   = 2'd0;
        if (w_pop) begin
            w_popCnt = w_is32 ? 2'd2 : 2'd1;
        end
    end

    // A response is only ever presented when its two halfwords are already reserved.
    always_comb begin
        w_freeHw  = DEPTH - r_occ;
        w_ack     = (w_freeHw >= OW'(2));
        w_rsp     = i_imem_recv & w_ack;
        w_grant   = r_imemReq & i_imem_gnt;
        w_push    = w_rsp & (r_ignCnt == '0) & ~i_cf_req;
        w_pushCnt = 2'd0;
        if (w_push) begin
            w_pushCnt = r_misaligned ? 2'd1 : 2'd2;
        end
        w_outNext = r_outCnt + CW'(w_grant) - CW'(w_rsp);
        w_occNext = r_occ + OW'(w_pushCnt) - OW'(w_popCnt);
        if (i_cf_req) begin
            w_occNext = '0;
        end
        w_freeNext = WW'(DEPTH - w_occNext);
        w_needHw   = (WW'(w_outNext) + WW'(1)) << 1;
        w_reqNext  = ~i_cf_req & (w_outNext < MAX_OUT) & (w_freeNext >= w_needHw);
    end

    always_ff @(posedge g_clk) begin
        if (w_push) begin
            if (r_misaligned) begin
                r_qData[r_wrPtr] <= i_imem_rdata[31:16];
                r_qErr[r_wrPtr]  <= i_imem_error;
            end else begin
                r_qData[r_wrPtr]  <= i_imem_rdata[15:0];
                r_qErr[r_wrPtr]   <= i_imem_error;
                r_qData[w_wrPtr1] <= i_imem_rdata[31:16];
                r_qErr[w_wrPtr1]  <= i_imem_error;
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_occ   <= '0;
        end else if (i_cf_req) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_occ   <= '0;
        end else begin
            r_rdPtr <= ptrAdd(r_rdPtr, w_popCnt);
            r_wrPtr <= ptrAdd(r_wrPtr, w_pushCnt);
            r_occ   <= w_occNext;
        end
    end

    // Responses already in flight at a redirect belong to the old stream and are dropped.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_outCnt     <= '0;
            r_ignCnt     <= '0;
            r_misaligned <= 1'b0;
            r_imemReq    <= 1'b0;
        end else begin
            r_outCnt  <= w_outNext;
            r_imemReq <= w_reqNext;
            if (i_cf_req) begin
                r_ignCnt     <= w_outNext;
                r_misaligned <= i_cf_target[1];
            end else begin
                if (w_rsp && (r_ignCnt != '0)) begin
                    r_ignCnt <= r_ignCnt - CW'(1);
                end
                if (w_push) begin
                    r_misaligned <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_imemAddr <= PC_RESET;
            r_s1Pc     <= PC_RESET;
        end else if (i_cf_req) begin
            r_imemAddr <= i_cf_target & ~XLEN'(3);
            r_s1Pc     <= i_cf_target & ~XLEN'(1);
        end else begin
            if (w_grant) begin
                r_imemAddr <= r_imemAddr + XLEN'(4);
            end
            if (w_pop) begin
                r_s1Pc <= r_s1Pc + (w_is32 ? XLEN'(4) : XLEN'(2));
            end
        end
    end

    assign o_cf_ack    = 1'b1;
    assign o_imem_req  = r_imemReq;
    assign o_imem_addr = r_imemAddr;
    assign o_imem_ack  = w_ack;
    assign o_s1_valid  = w_s1Valid;
    assign o_s1_size   = w_is32;
    assign o_s1_pc     = r_s1Pc;
    assign o_s1_data   = w_is32 ? {w_head1, w_head0} : {16'h0000, w_head0};
    assign o_s1_error  = w_is32 ? (w_headErr0 | w_headErr1) : w_headErr0;

endmodule

// File: tb/tb_frv_pipeline_fetch_pq.sv
// tb_frv_pipeline_fetch_pq: directed bench for the prefetching fetch stage.
// A small in-order memory model answers granted reads; emitted instructions are compared to hand-computed lists.
module tb_frv_pipeline_fetch_pq;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        i_cf_req;
    logic [31:0] i_cf_target;
    logic        o_cf_ack;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_recv;
    logic        o_imem_ack;
    logic        i_imem_error;
    logic [31:0] i_imem_rdata;
    logic        o_s1_valid;
    logic        i_s1_busy;
    logic [31:0] o_s1_data;
    logic        o_s1_size;
    logic [31:0] o_s1_pc;
    logic        o_s1_error;

    typedef struct {
        logic        gnt;
        logic        recvEn;
        logic        busy;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expPc;
        logic [31:0] expData;
    } vecEntry_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        size;
        logic        err;
    } insn_t;

    vecEntry_t   vecs [6];
    insn_t       emitted [$];
    insn_t       expQ [$];
    logic [31:0] pend [$];
    logic        memGnt;
    logic        memRecvEn;
    logic [31:0] errAddr;
    int          grantCount;
    int          compareCount;
    int          mismatchCount;

    frv_pipeline_fetch_pq dut (
        .g_clk        (g_clk),
        .g_resetn     (g_resetn),
        .i_cf_req     (i_cf_req),
        .i_cf_target  (i_cf_target),
        .o_cf_ack     (o_cf_ack),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_gnt   (i_imem_gnt),
        .i_imem_recv  (i_imem_recv),
        .o_imem_ack   (o_imem_ack),
        .i_imem_error (i_imem_error),
        .i_imem_rdata (i_imem_rdata),
        .o_s1_valid   (o_s1_valid),
        .i_s1_busy    (i_s1_busy),
        .o_s1_data    (o_s1_data),
        .o_s1_size    (o_s1_size),
        .o_s1_pc      (o_s1_pc),
        .o_s1_error   (o_s1_error)
    );

    always #5 g_clk = ~g_clk;

    // Default words are 32-bit opcodes tagged with the low half of their own address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'h8000_0100: return 32'h1235_FFFF;
            32'h8000_0200: return 32'h0001_4501;
            32'h8000_0204: return 32'h1113_4009;
            32'h8000_0208: return 32'h4005_ABCD;
            default:       return {a[15:0], 16'h0003};
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compareCount++;
        if (act !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: present the memory response, record handshakes and pops, step the clock.
    task automatic applyStimulus();
        logic        grantNow;
        logic        rspNow;
        logic        popNow;
        logic [31:0] grantAddr;
        insn_t       rec;
        i_imem_gnt = memGnt;
        if (memRecvEn && pend.size() > 0) begin
            i_imem_recv  = 1'b1;
            i_imem_rdata = memWord(pend[0]);
            i_imem_error = (pend[0] == errAddr);
        end else begin
            i_imem_recv  = 1'b0;
            i_imem_rdata = 32'hDEAD_BEEF;
            i_imem_error = 1'b0;
        end
        #1;
        grantNow  = o_imem_req & i_imem_gnt;
        grantAddr = o_imem_addr;
        rspNow    = i_imem_recv & o_imem_ack;
        popNow    = o_s1_valid & ~i_s1_busy & ~i_cf_req;
        rec.pc    = o_s1_pc;
        rec.data  = o_s1_data;
        rec.size  = o_s1_size;
        rec.err   = o_s1_error;
        @(posedge g_clk);
        #1;
        if (rspNow && pend.size() > 0) begin
            void'(pend.pop_front());
        end
        if (grantNow) begin
            pend.push_back(grantAddr);
            grantCount++;
        end
        if (popNow) begin
            emitted.push_back(rec);
        end
    endtask

    task automatic doReset();
        g_resetn     = 1'b0;
        i_cf_req     = 1'b0;
        i_cf_target  = 32'h0;
        i_s1_busy    = 1'b0;
        i_imem_gnt   = 1'b0;
        i_imem_recv  = 1'b0;
        i_imem_error = 1'b0;
        i_imem_rdata = 32'h0;
        memGnt       = 1'b0;
        memRecvEn    = 1'b0;
        errAddr      = 32'hFFFF_FFFF;
        grantCount   = 0;
        pend.delete();
        emitted.delete();
        repeat (3) @(posedge g_clk);
        #1;
        g_resetn = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] target);
        i_cf_req    = 1'b1;
        i_cf_target = target;
        memGnt      = 1'b0;
        emitted.delete();
        applyStimulus();
        i_cf_req = 1'b0;
        memGnt   = 1'b1;
    endtask

    task automatic collectAndCheck(input int n, input int budget, input string tag);
        int cyc = 0;
        while (emitted.size() < n && cyc < budget) begin
            applyStimulus();
            cyc++;
        end
        checkOutput({tag, "_count"}, 32'(emitted.size() >= n), 32'd1);
        for (int i = 0; i < expQ.size() && i < emitted.size(); i++) begin
            checkOutput($sformatf("%s_pc%0d", tag, i), emitted[i].pc, expQ[i].pc);
            checkOutput($sformatf("%s_data%0d", tag, i), emitted[i].data, expQ[i].data);
            checkOutput($sformatf("%s_size%0d", tag, i), 32'(emitted[i].size), 32'(expQ[i].size));
            checkOutput($sformatf("%s_err%0d", tag, i), 32'(emitted[i].err), 32'(expQ[i].err));
        end
    endtask

    function automatic insn_t mk(input logic [31:0] pc, input logic [31:0] data, input logic size, input logic err);
        insn_t r;
        r.pc   = pc;
        r.data = data;
        r.size = size;
        r.err  = err;
        return r;
    endfunction

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compareCount  = 0;
        mismatchCount = 0;

        // Cycle-by-cycle expectations after reset with single-cycle memory latency.
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 32'h8000_0000, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h8000_0000, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0004, 1'b0, 32'h8000_0000, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0000, 32'h0000_0003};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0004, 32'h0004_0003};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0008, 32'h0008_0003};

        doReset();
        checkOutput("rst_req", 32'(o_imem_req), 32'd0);
        checkOutput("rst_addr", o_imem_addr, 32'h8000_0000);
        checkOutput("rst_pc", o_s1_pc, 32'h8000_0000);
        checkOutput("rst_valid", 32'(o_s1_valid), 32'd0);
        checkOutput("rst_cfack", 32'(o_cf_ack), 32'd1);
        checkOutput("rst_ack", 32'(o_imem_ack), 32'd1);

        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("t1_req%0d", i), 32'(o_imem_req), 32'(vecs[i].expReq));
            checkOutput($sformatf("t1_addr%0d", i), o_imem_addr, vecs[i].expAddr);
            checkOutput($sformatf("t1_valid%0d", i), 32'(o_s1_valid), 32'(vecs[i].expValid));
            checkOutput($sformatf("t1_pc%0d", i), o_s1_pc, vecs[i].expPc);
            if (vecs[i].expValid) begin
                checkOutput($sformatf("t1_data%0d", i), o_s1_data, vecs[i].expData);
                checkOutput($sformatf("t1_size%0d", i), 32'(o_s1_size), 32'd1);
            end
            memGnt    = vecs[i].gnt;
            memRecvEn = vecs[i].recvEn;
            i_s1_busy = vecs[i].busy;
            applyStimulus();
        end

        // No responses: the in-flight limit must cap the grants.
        doReset();
        memGnt    = 1'b1;
        memRecvEn = 1'b0;
        repeat (12) applyStimulus();
        checkOutput("t2_grants", 32'(grantCount), 32'd4);
        checkOutput("t2_req_low", 32'(o_imem_req), 32'd0);
        checkOutput("t2_pending", 32'(pend.size()), 32'd4);
        memRecvEn = 1'b1;
        for (int k = 0; k < 10 && !o_imem_req; k++) begin
            applyStimulus();
        end
        checkOutput("t2_reissue", 32'(o_imem_req), 32'd1);

        // Redirect to a misaligned target with three reads in flight.
        doReset();
        memGnt    = 1'b1;
        memRecvEn = 1'b0;
        for (int k = 0; k < 10 && grantCount < 3; k++) begin
            applyStimulus();
        end
        checkOutput("t3_grants", 32'(grantCount), 32'd3);
        redirect(32'h8000_0102);
        checkOutput("t3_addr", o_imem_addr, 32'h8000_0100);
        checkOutput("t3_req_off", 32'(o_imem_req), 32'd0);
        checkOutput("t3_pc", o_s1_pc, 32'h8000_0102);
        checkOutput("t3_valid", 32'(o_s1_valid), 32'd0);
        memRecvEn = 1'b1;
        applyStimulus();
        checkOutput("t3_req_on", 32'(o_imem_req), 32'd1);
        checkOutput("t3_addr2", o_imem_addr, 32'h8000_0100);
        expQ.delete();
        expQ.push_back(mk(32'h8000_0102, 32'h0000_1235, 1'b0, 1'b0));
        expQ.push_back(mk(32'h8000_0104, 32'h0104_0003, 1'b1, 1'b0));
        collectAndCheck(2, 30, "t3");

        // Compressed pairs, a word-spanning 32-bit insn, and a bus error on its second word.
        errAddr = 32'h8000_0208;
        redirect(32'h8000_0200);
        expQ.delete();
        expQ.push_back(mk(32'h8000_0200, 32'h0000_4501, 1'b0, 1'b0));
        expQ.push_back(mk(32'h8000_0202, 32'h0000_0001, 1'b0, 1'b0));
        expQ.push_back(mk(32'h8000_0204, 32'h0000_4009, 1'b0, 1'b0));
        expQ.push_back(mk(32'h8000_0206, 32'hABCD_1113, 1'b1, 1'b1));
        expQ.push_back(mk(32'h8000_020A, 32'h0000_4005, 1'b0, 1'b1));
        expQ.push_back(mk(32'h8000_020C, 32'h020C_0003, 1'b1, 1'b0));
        collectAndCheck(6, 40, "t4");

        // Decode stalled long enough for the queue to fill completely.
        errAddr   = 32'hFFFF_FFFF;
        i_s1_busy = 1'b1;
        redirect(32'h8000_0300);
        grantCount = 0;
        repeat (20) applyStimulus();
        checkOutput("t6_grants", 32'(grantCount), 32'd4);
        checkOutput("t6_req_low", 32'(o_imem_req), 32'd0);
        checkOutput("t6_valid", 32'(o_s1_valid), 32'd1);
        checkOutput("t6_pc_hold", o_s1_pc, 32'h8000_0300);
        checkOutput("t6_pending", 32'(pend.size()), 32'd0);
        checkOutput("t6_no_pop", 32'(emitted.size()), 32'd0);
        i_s1_busy = 1'b0;
        expQ.delete();
        for (int k = 0; k < 8; k++) begin
            logic [31:0] pc;
            pc = 32'h8000_0300 + 32'(4 * k);
            expQ.push_back(mk(pc, {pc[15:0], 16'h0003}, 1'b1, 1'b0));
        end
        collectAndCheck(8, 60, "t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
